multiband_eq_engine: RTL and testbench

- Time-multiplexed, parametrised successor to the fixed three-band, single-channel equaliser.
- One shared multiply-accumulate datapath evaluates NUM_BANDS parallel biquads for NUM_CH interleaved channels; the band outputs are summed and saturated.
- Coefficients are double-buffered: SPI-side writes land in a shadow bank and move to the active bank only at a sample boundary, so coefficient updates never cause glitches.
- Sits between the I2S receive latch and the I2S transmit data word.

---
 rtl/eq_pkg.sv | 39 +++
 rtl/eq_mac_datapath.sv | 74 +++++++
 rtl/multiband_eq_engine.sv | 211 +++++++++++++++++++++
 tb/tb_multiband_eq_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types, constants and helpers for the multiband equaliser engine.
// Coefficient taps, FSM states, saturation and the passthrough reset bank.
package eq_pkg;

  localparam int NUM_TAPS = 5;

  typedef enum logic [2:0] {
    TAP_B0 = 3'd0,
    TAP_B1 = 3'd1,
    TAP_B2 = 3'd2,
    TAP_A1 = 3'd3,
    TAP_A2 = 3'd4
  } tap_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Passthrough bank: unity b0 on band 0, every other coefficient zero.
  function automatic logic signed [63:0] passthrough_coef(input int band, input int tap,
                                                          input int coef_frac);
    if (band == 0 && tap == int'(TAP_B0)) return 64'sd1 <<< coef_frac;
    return 64'sd0;
  endfunction

  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/eq_mac_datapath.sv
// Shared multiply-accumulate datapath: one product per cycle, per-band
// finalise (shift, saturate) and a running sum of saturated band outputs.
module eq_mac_datapath
  import eq_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = 40
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     mac_en_i,
  input  logic                     subtract_i,
  input  logic                     band_last_i,
  input  logic signed [DATA_W-1:0] operand_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [DATA_W-1:0] band_y_o,
  output logic signed [DATA_W-1:0] sum_o,
  output logic                     sat_o
);

  // Up to 8 saturated bands fit in DATA_W+3 bits; one spare bit for margin.
  localparam int SUM_W = DATA_W + 4;

  logic signed [ACC_W-1:0]         acc_q, acc_d, acc_next;
  logic signed [SUM_W-1:0]         sum_q, sum_d;
  logic                            band_sat_q, band_sat_d;
  logic signed [DATA_W+COEF_W-1:0] product;
  logic signed [63:0]              band_wide, band_clip, sum_wide, sum_clip;

  always_comb begin
    product   = operand_i * coef_i;
    acc_next  = subtract_i ? acc_q - ACC_W'(product) : acc_q + ACC_W'(product);
    band_wide = 64'(acc_next >>> COEF_FRAC);
    band_clip = sat_to_width(band_wide, DATA_W);
    band_y_o  = band_clip[DATA_W-1:0];
    sum_wide  = 64'(sum_q);
    sum_clip  = sat_to_width(sum_wide, DATA_W);
    sum_o     = sum_clip[DATA_W-1:0];
    sat_o     = band_sat_q || (sum_clip != sum_wide);

    acc_d      = acc_q;
    sum_d      = sum_q;
    band_sat_d = band_sat_q;
    if (clear_i) begin
      acc_d      = '0;
      sum_d      = '0;
      band_sat_d = 1'b0;
    end else if (mac_en_i) begin
      if (band_last_i) begin
        acc_d = '0;
        sum_d = sum_q + SUM_W'(band_y_o);
        if (band_clip != band_wide) band_sat_d = 1'b1;
      end else begin
        acc_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q      <= '0;
      sum_q      <= '0;
      band_sat_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      band_sat_q <= band_sat_d;
    end
  end

endmodule

// File: rtl/multiband_eq_engine.sv
// Time-multiplexed NUM_BANDS x NUM_CH parallel biquad equaliser with
// double-buffered coefficients swapped only while the engine is idle.
module multiband_eq_engine
  import eq_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int NUM_BANDS = 3,
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = 40,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BAND_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_valid_i,
  input  logic [CH_W-1:0]          sample_ch_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic                     sample_ready_o,
  input  logic                     coef_wr_en_i,
  input  logic [2:0]               coef_wr_band_i,
  input  logic [2:0]               coef_wr_idx_i,
  input  logic signed [COEF_W-1:0] coef_wr_data_i,
  input  logic                     coef_commit_i,
  output logic                     commit_pending_o,
  output logic                     out_valid_o,
  output logic [CH_W-1:0]          out_ch_o,
  output logic signed [DATA_W-1:0] out_sample_o,
  output logic                     sat_o
);

  logic signed [COEF_W-1:0] shadow_q [NUM_BANDS][NUM_TAPS], shadow_d [NUM_BANDS][NUM_TAPS];
  logic signed [COEF_W-1:0] active_q [NUM_BANDS][NUM_TAPS], active_d [NUM_BANDS][NUM_TAPS];
  logic signed [DATA_W-1:0] x1_q [NUM_CH], x1_d [NUM_CH], x2_q [NUM_CH], x2_d [NUM_CH];
  logic signed [DATA_W-1:0] y1_q [NUM_CH][NUM_BANDS], y1_d [NUM_CH][NUM_BANDS];
  logic signed [DATA_W-1:0] y2_q [NUM_CH][NUM_BANDS], y2_d [NUM_CH][NUM_BANDS];

  state_e                   state_q, state_d;
  logic [BAND_W-1:0]        band_q, band_d;
  tap_e                     tap_q, tap_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic                     pending_q, pending_d;
  logic                     out_valid_q, out_valid_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
  logic                     out_sat_q, out_sat_d;

  logic                     accept;
  logic                     subtract;
  logic signed [DATA_W-1:0] operand;
  logic signed [COEF_W-1:0] coef;
  logic signed [DATA_W-1:0] band_y, dp_sum;
  logic                     dp_sat;

  assign accept           = (state_q == ST_IDLE) && sample_valid_i && (int'(sample_ch_i) < NUM_CH);
  assign sample_ready_o   = (state_q == ST_IDLE);
  assign commit_pending_o = pending_q;
  assign out_valid_o      = out_valid_q;
  assign out_ch_o         = out_ch_q;
  assign out_sample_o     = out_sample_q;
  assign sat_o            = out_sat_q;

  // Feedback taps subtract, so a1/a2 are stored with their textbook sign.
  always_comb begin
    operand  = x_q;
    subtract = 1'b0;
    coef     = active_q[band_q][tap_q];
    case (tap_q)
      TAP_B1:  operand = x1_q[ch_q];
      TAP_B2:  operand = x2_q[ch_q];
      TAP_A1: begin
        operand  = y1_q[ch_q][band_q];
        subtract = 1'b1;
      end
      TAP_A2: begin
        operand  = y2_q[ch_q][band_q];
        subtract = 1'b1;
      end
      default: operand = x_q;
    endcase
  end

  eq_mac_datapath #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .ACC_W     (ACC_W)
  ) u_datapath (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (accept),
    .mac_en_i    (state_q == ST_MAC),
    .subtract_i  (subtract),
    .band_last_i (tap_q == TAP_A2),
    .operand_i   (operand),
    .coef_i      (coef),
    .band_y_o    (band_y),
    .sum_o       (dp_sum),
    .sat_o       (dp_sat)
  );

  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y1_d         = y1_q;
    y2_d         = y2_q;
    state_d      = state_q;
    band_d       = band_q;
    tap_d        = tap_q;
    x_d          = x_q;
    ch_d         = ch_q;
    pending_d    = pending_q;
    out_valid_d  = 1'b0;
    out_ch_d     = out_ch_q;
    out_sample_d = out_sample_q;
    out_sat_d    = out_sat_q;

    if (coef_wr_en_i && int'(coef_wr_band_i) < NUM_BANDS && int'(coef_wr_idx_i) < NUM_TAPS)
      shadow_d[coef_wr_band_i[BAND_W-1:0]][coef_wr_idx_i] = coef_wr_data_i;
    if (coef_commit_i) pending_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // Copy from shadow_d so a same-cycle write is part of the commit.
        if (pending_q || coef_commit_i) begin
          active_d  = shadow_d;
          pending_d = 1'b0;
        end
        if (accept) begin
          x_d     = sample_i;
          ch_d    = sample_ch_i;
          band_d  = '0;
          tap_d   = TAP_B0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (tap_q == TAP_A2) begin
          y2_d[ch_q][band_q] = y1_q[ch_q][band_q];
          y1_d[ch_q][band_q] = band_y;
          tap_d              = TAP_B0;
          if (int'(band_q) == NUM_BANDS - 1) state_d = ST_DONE;
          else band_d = band_q + BAND_W'(1);
        end else begin
          tap_d = tap_e'(tap_q + 3'd1);
        end
      end
      ST_DONE: begin
        x2_d[ch_q]   = x1_q[ch_q];
        x1_d[ch_q]   = x_q;
        out_valid_d  = 1'b1;
        out_ch_d     = ch_q;
        out_sample_d = dp_sum;
        out_sat_d    = dp_sat;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          shadow_q[b][t] <= COEF_W'(passthrough_coef(b, t, COEF_FRAC));
          active_q[b][t] <= COEF_W'(passthrough_coef(b, t, COEF_FRAC));
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
          y1_q[c][b] <= '0;
          y2_q[c][b] <= '0;
        end
      end
      state_q      <= ST_IDLE;
      band_q       <= '0;
      tap_q        <= TAP_B0;
      x_q          <= '0;
      ch_q         <= '0;
      pending_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
      state_q      <= state_d;
      band_q       <= band_d;
      tap_q        <= tap_d;
      x_q          <= x_d;
      ch_q         <= ch_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_sample_q <= out_sample_d;
      out_sat_q    <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_multiband_eq_engine.sv
// Directed bench for multiband_eq_engine: passthrough, commit gating,
// recursion, saturation, busy behaviour and mid-operation reset.
module tb_multiband_eq_engine;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     sample_valid_i;
  logic [0:0]               sample_ch_i;
  logic signed [DATA_W-1:0] sample_i;
  logic                     sample_ready_o;
  logic                     coef_wr_en_i;
  logic [2:0]               coef_wr_band_i;
  logic [2:0]               coef_wr_idx_i;
  logic signed [COEF_W-1:0] coef_wr_data_i;
  logic                     coef_commit_i;
  logic                     commit_pending_o;
  logic                     out_valid_o;
  logic [0:0]               out_ch_o;
  logic signed [DATA_W-1:0] out_sample_o;
  logic                     sat_o;

  int checks = 0;
  int errors = 0;
  int valid_pulses = 0;

  multiband_eq_engine dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sample_valid_i   (sample_valid_i),
    .sample_ch_i      (sample_ch_i),
    .sample_i         (sample_i),
    .sample_ready_o   (sample_ready_o),
    .coef_wr_en_i     (coef_wr_en_i),
    .coef_wr_band_i   (coef_wr_band_i),
    .coef_wr_idx_i    (coef_wr_idx_i),
    .coef_wr_data_i   (coef_wr_data_i),
    .coef_commit_i    (coef_commit_i),
    .commit_pending_o (commit_pending_o),
    .out_valid_o      (out_valid_o),
    .out_ch_o         (out_ch_o),
    .out_sample_o     (out_sample_o),
    .sat_o            (sat_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid_o === 1'b1) valid_pulses++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic writeCoef(input int band, input int idx, input int value);
    @(negedge clk);
    coef_wr_en_i   = 1'b1;
    coef_wr_band_i = 3'(band);
    coef_wr_idx_i  = 3'(idx);
    coef_wr_data_i = COEF_W'(value);
    @(negedge clk);
    coef_wr_en_i = 1'b0;
  endtask

  task automatic commitBank();
    @(negedge clk);
    coef_commit_i = 1'b1;
    @(negedge clk);
    coef_commit_i = 1'b0;
  endtask

  // Leaves the bench at the negedge right after the accept edge.
  task automatic startSample(input int ch, input int value);
    @(negedge clk);
    sample_valid_i = 1'b1;
    sample_ch_i    = 1'(ch);
    sample_i       = DATA_W'(value);
    @(posedge clk);
    @(negedge clk);
    sample_valid_i = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 100) begin
      if (out_valid_o) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    if (!got) checkOutput("result_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input string tag, input int ch, input int value,
                               input int exp_out, input logic exp_sat);
    int lat;
    startSample(ch, value);
    waitResult(lat);
    checkOutput({tag, "_out"}, out_sample_o, exp_out);
    checkOutput({tag, "_ch"}, out_ch_o, ch);
    checkOutput({tag, "_sat"}, sat_o, exp_sat);
  endtask

  initial begin
    int lat;
    int pulses_before;
    int rec_ch [7]  = '{0, 1, 0, 1, 0, 1, 0};
    int rec_in [7]  = '{1000, 0, 0, 0, 0, 0, 0};
    int rec_exp [7] = '{1000, 0, 500, 0, 250, 0, 125};

    reset_n        = 1'b0;
    sample_valid_i = 1'b0;
    sample_ch_i    = '0;
    sample_i       = '0;
    coef_wr_en_i   = 1'b0;
    coef_wr_band_i = '0;
    coef_wr_idx_i  = '0;
    coef_wr_data_i = '0;
    coef_commit_i  = 1'b0;

    $display("[TB] reset passthrough");
    doReset();
    checkOutput("rst_ready", sample_ready_o, 1);
    checkOutput("rst_valid", out_valid_o, 0);
    checkOutput("rst_sample", out_sample_o, 0);
    checkOutput("rst_ch", out_ch_o, 0);
    checkOutput("rst_sat", sat_o, 0);
    checkOutput("rst_pending", commit_pending_o, 0);
    startSample(0, 1000);
    checkOutput("busy_ready", sample_ready_o, 0);
    waitResult(lat);
    checkOutput("pt_latency", lat, 16);
    checkOutput("pt_out", out_sample_o, 1000);
    checkOutput("pt_ch", out_ch_o, 0);
    checkOutput("pt_sat", sat_o, 0);
    applyStimulus("pt_neg", 1, -1234, -1234, 1'b0);

    $display("[TB] commit gating");
    doReset();
    writeCoef(0, 0, 8192);
    applyStimulus("gate_old", 0, 2000, 2000, 1'b0);
    commitBank();
    checkOutput("gate_pending", commit_pending_o, 0);
    applyStimulus("gate_new", 0, 2000, 1000, 1'b0);

    $display("[TB] ignored coefficient writes");
    doReset();
    writeCoef(4, 0, 8192);
    writeCoef(0, 5, 8192);
    commitBank();
    applyStimulus("ign_wr", 0, 1000, 1000, 1'b0);

    $display("[TB] recursion and channel isolation");
    doReset();
    writeCoef(0, 0, 16384);
    writeCoef(0, 3, -8192);
    commitBank();
    for (int i = 0; i < 7; i++)
      applyStimulus($sformatf("rec%0d", i), rec_ch[i], rec_in[i], rec_exp[i], 1'b0);

    $display("[TB] saturation");
    doReset();
    writeCoef(1, 0, 16384);
    commitBank();
    applyStimulus("sat_pos", 0, 30000, 32767, 1'b1);
    applyStimulus("sat_neg", 0, -30000, -32768, 1'b1);
    applyStimulus("sat_none", 0, 100, 200, 1'b0);

    $display("[TB] commit while busy");
    doReset();
    writeCoef(0, 0, 8192);
    pulses_before = valid_pulses;
    startSample(0, 2000);
    repeat (6) @(negedge clk);
    coef_commit_i  = 1'b1;
    sample_valid_i = 1'b1;
    sample_ch_i    = 1'b1;
    sample_i       = 16'sd500;
    @(negedge clk);
    coef_commit_i  = 1'b0;
    sample_valid_i = 1'b0;
    checkOutput("busy_pending_set", commit_pending_o, 1);
    checkOutput("busy_not_ready", sample_ready_o, 0);
    waitResult(lat);
    checkOutput("busy_old_bank", out_sample_o, 2000);
    checkOutput("busy_pending_hold", commit_pending_o, 1);
    @(negedge clk);
    checkOutput("busy_pending_clr", commit_pending_o, 0);
    checkOutput("busy_hold_out", out_sample_o, 2000);
    checkOutput("busy_one_pulse", valid_pulses - pulses_before, 1);
    applyStimulus("busy_new_bank", 0, 2000, 1000, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("busy_no_extra", valid_pulses - pulses_before, 2);

    $display("[TB] reset mid-MAC");
    doReset();
    writeCoef(0, 0, 16384);
    writeCoef(0, 3, -8192);
    commitBank();
    applyStimulus("mid_first", 0, 1000, 1000, 1'b0);
    startSample(0, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("mid_ready", sample_ready_o, 1);
    pulses_before = valid_pulses;
    repeat (25) @(negedge clk);
    checkOutput("mid_no_valid", valid_pulses - pulses_before, 0);
    writeCoef(0, 0, 16384);
    writeCoef(0, 3, -8192);
    commitBank();
    applyStimulus("mid_fresh0", 0, 1000, 1000, 1'b0);
    applyStimulus("mid_fresh1", 0, 0, 500, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
